// File: rtl/prom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prom_arb_pkg
// Description : Shared widths, requester-id type and tag-pipeline stage
//               record for the pattern-PROM port-A arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package prom_arb_pkg;

    // Address and data widths of the 128x36 pattern PROM
    localparam int AW = 7;
    localparam int DW = 36;

    // Number of tag stages between accept and the read response
    localparam int PIPE_DEPTH = 3;

    // Requester identifier: 0 = pattern sequencer, 1 = host/config loader
    typedef logic req_id_t;

    localparam req_id_t REQ_SEQ  = 1'b0;
    localparam req_id_t REQ_HOST = 1'b1;

    // One stage of the in-flight request tracker
    typedef struct packed {
        logic    vld;   // an accept happened in the originating cycle
        req_id_t id;    // which requester it belongs to
        logic    rd;    // 1 = read (expects a response), 0 = write
    } tag_t;

endpackage : prom_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone request is always
//               granted; on contention the pointer's requester wins, and
//               after every grant the pointer moves to the other requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import prom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    // Pointer names the requester favoured on the next contended cycle
    req_id_t ptr_q;
    req_id_t ptr_d;
    logic [1:0] grant_w;

    // Grant decode; nothing is granted while reset is held
    always_comb begin
        grant_w = 2'b00;
        unique case (valid_i)
            2'b01:   grant_w = 2'b01;
            2'b10:   grant_w = 2'b10;
            2'b11:   grant_w = (ptr_q == REQ_HOST) ? 2'b10 : 2'b01;
            default: grant_w = 2'b00;
        endcase
        if (rst) begin
            grant_w = 2'b00;
        end
    end

    assign grant_o = grant_w;

    // Next pointer: hand priority to whichever requester just lost out
    always_comb begin
        ptr_d = ptr_q;
        if (grant_w[0]) begin
            ptr_d = REQ_HOST;
        end else if (grant_w[1]) begin
            ptr_d = REQ_SEQ;
        end
    end

    // Pointer register, reset to favour the pattern sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_SEQ;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/prom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prom_port_arbiter
// Description : Shares port A of the 128x36 pattern PROM between the
//               pattern sequencer (r0) and the host/config loader (r1).
//               Valid/ready request handshake, round-robin grant, one
//               accept per cycle, in-order read responses with a fixed
//               latency of three cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module prom_port_arbiter
    import prom_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    // requester 0 : pattern sequencer
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    // requester 1 : host/config loader
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    // PROM port A
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic [1:0]    grant_w;
    logic          accept_w;
    req_id_t       sel_w;
    logic          req_we_w;
    logic [AW-1:0] req_addr_w;
    logic [DW-1:0] req_wdata_w;

    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q,   ram_we_d;
    logic [DW-1:0] ram_din_q,  ram_din_d;

    // tag_q[0] is visible in T+1, tag_q[1] in T+2 (RAM data valid),
    // tag_q[2] in T+3 (response presented to the requester)
    tag_t tag_q [PIPE_DEPTH];
    tag_t tag_d;

    logic [DW-1:0] rdata_q [2];

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .valid_i ({r1_valid, r0_valid}),
        .grant_o (grant_w)
    );

    assign r0_ready = grant_w[0];
    assign r1_ready = grant_w[1];

    // Select the granted requester's fields for the RAM command
    always_comb begin
        accept_w    = |grant_w;
        sel_w       = grant_w[1] ? REQ_HOST : REQ_SEQ;
        req_we_w    = grant_w[1] ? r1_we    : r0_we;
        req_addr_w  = grant_w[1] ? r1_addr  : r0_addr;
        req_wdata_w = grant_w[1] ? r1_wdata : r0_wdata;
    end

    // Next RAM command: address/data hold when idle, write strobe drops
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        tag_d      = '0;
        if (accept_w) begin
            ram_addr_d = req_addr_w;
            ram_din_d  = req_wdata_w;
            ram_we_d   = req_we_w;
            tag_d.vld  = 1'b1;
            tag_d.id   = sel_w;
            tag_d.rd   = ~req_we_w;
        end
    end

    // RAM command registers; a write already on the port when reset
    // arrives is still sampled by the RAM on that same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;
    assign ram_din  = ram_din_q;

    // Tag shift register; reset drops every outstanding response
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic          load_w;
            logic [DW-1:0] rdata_d;

            // Capture RAM output when the read in stage 1 belongs to us
            always_comb begin
                load_w  = tag_q[1].vld && tag_q[1].rd &&
                          (tag_q[1].id == req_id_t'(gi));
                rdata_d = load_w ? ram_dout : rdata_q[gi];
            end

            // Per-requester read data register, holds between responses
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q[gi] <= '0;
                end else begin
                    rdata_q[gi] <= rdata_d;
                end
            end
        end
    endgenerate

    assign r0_rdata  = rdata_q[0];
    assign r1_rdata  = rdata_q[1];
    assign r0_rvalid = tag_q[2].vld && tag_q[2].rd && (tag_q[2].id == REQ_SEQ);
    assign r1_rvalid = tag_q[2].vld && tag_q[2].rd && (tag_q[2].id == REQ_HOST);

endmodule : prom_port_arbiter
`default_nettype wire

// File: tb/tb_prom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prom_port_arbiter
// Description : Self-checking bench for prom_port_arbiter with a behavioural
//               PROM, a reference memory and an in-order response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prom_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rv_seen = 0;

    prom_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int a);
        return 36'h000085007 ^ (36'(a) * 36'h100010001);
    endfunction

    // Behavioural PROM port A, output register disabled
    logic [DW-1:0] ram_mem [128];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference memory, updated in accept order
    logic [DW-1:0] model [128];

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = init_word(i);
            model[i]   = init_word(i);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;
    exp_t sb [$];

    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;

    // Scoreboard monitor: responses checked, then new accepts recorded
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            last0 = '0;
            last1 = '0;
        end else begin
            chk("one_ready", 64'(r0_ready && r1_ready), 64'd0);
            chk("work_conserving", 64'(r0_ready || r1_ready), 64'(r0_valid || r1_valid));
            if (r0_rvalid) begin
                rv_seen++;
                if (sb.size() == 0) chk("r0_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("r0_resp_id", 64'd0, 64'(e.id));
                    chk("r0_rdata", 64'(r0_rdata), 64'(e.data));
                    chk("r0_latency", 64'(cyc - e.acc), 64'd3);
                    last0 = e.data;
                end
            end else begin
                chk("r0_rdata_hold", 64'(r0_rdata), 64'(last0));
            end
            if (r1_rvalid) begin
                rv_seen++;
                if (sb.size() == 0) chk("r1_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("r1_resp_id", 64'd1, 64'(e.id));
                    chk("r1_rdata", 64'(r1_rdata), 64'(e.data));
                    chk("r1_latency", 64'(cyc - e.acc), 64'd3);
                    last1 = e.data;
                end
            end else begin
                chk("r1_rdata_hold", 64'(r1_rdata), 64'(last1));
            end
            if (sb.size() > 0 && cyc > sb[0].acc + 3) begin
                chk("missing_response", 64'(cyc - sb[0].acc), 64'd3);
                void'(sb.pop_front());
            end
            if (r0_valid && r0_ready) begin
                if (r0_we) model[r0_addr] = r0_wdata;
                else sb.push_back('{id: 1'b0, data: model[r0_addr], acc: cyc});
            end
            if (r1_valid && r1_ready) begin
                if (r1_we) model[r1_addr] = r1_wdata;
                else sb.push_back('{id: 1'b1, data: model[r1_addr], acc: cyc});
            end
        end
    end

    task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic v1, input logic we1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            idle(1);
            k++;
        end
        @(negedge clk);
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic          v0, we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rdy0, rdy1, rwe;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int b;
        logic [63:0] rnd;
        logic [DW-1:0] rd0, rd1;
        logic [AW-1:0] ra0, ra1;

        //          v0 we0 a0     d0               v1 we1 a1     d1               rdy0 rdy1 rwe
        tbl[0]  = '{1, 0, 7'h00, '0,              0, 0, 7'h00, '0,              1, 0, 0};
        tbl[1]  = '{1, 0, 7'h10, '0,              1, 0, 7'h20, '0,              0, 1, 0};
        tbl[2]  = '{1, 0, 7'h10, '0,              1, 0, 7'h21, '0,              1, 0, 0};
        tbl[3]  = '{1, 0, 7'h11, '0,              1, 0, 7'h21, '0,              0, 1, 0};
        tbl[4]  = '{1, 0, 7'h11, '0,              1, 0, 7'h22, '0,              1, 0, 0};
        tbl[5]  = '{0, 0, 7'h00, '0,              1, 1, 7'h7F, 36'h5A5A5A5A5,   0, 1, 0};
        tbl[6]  = '{1, 0, 7'h7F, '0,              0, 0, 7'h00, '0,              1, 0, 1};
        tbl[7]  = '{0, 0, 7'h00, '0,              1, 1, 7'h05, 36'h123456789,   0, 1, 0};
        tbl[8]  = '{0, 0, 7'h00, '0,              0, 0, 7'h00, '0,              0, 0, 1};
        tbl[9]  = '{0, 0, 7'h00, '0,              0, 0, 7'h00, '0,              0, 0, 0};
        tbl[10] = '{1, 0, 7'h01, '0,              0, 0, 7'h00, '0,              1, 0, 0};
        tbl[11] = '{1, 0, 7'h05, '0,              1, 0, 7'h05, '0,              0, 1, 0};
        tbl[12] = '{1, 0, 7'h05, '0,              0, 0, 7'h00, '0,              1, 0, 0};
        tbl[13] = '{1, 0, 7'h02, '0,              0, 0, 7'h00, '0,              1, 0, 0};

        // Reset with both requesters pushing: nothing may be granted
        rst = 1'b1;
        r0_valid = 1; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_r0_ready", 64'(r0_ready), 64'd0);
            chk("rst_r1_ready", 64'(r1_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        r0_valid = 0; r1_valid = 0;
        @(negedge clk);
        chk("rst_r0_rvalid", 64'(r0_rvalid), 64'd0);
        chk("rst_r1_rvalid", 64'(r1_rvalid), 64'd0);
        chk("rst_r0_rdata",  64'(r0_rdata),  64'd0);
        chk("rst_r1_rdata",  64'(r1_rdata),  64'd0);
        chk("rst_ram_we",    64'(ram_we),    64'd0);
        chk("rst_ram_addr",  64'(ram_addr),  64'd0);
        chk("rst_ram_din",   64'(ram_din),   64'd0);

        // Directed table: grant order, write-then-read, idle strobe, same address
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("tbl%0d_r0_ready", i), 64'(r0_ready), 64'(tbl[i].rdy0));
            chk($sformatf("tbl%0d_r1_ready", i), 64'(r1_ready), 64'(tbl[i].rdy1));
            chk($sformatf("tbl%0d_ram_we", i),   64'(ram_we),   64'(tbl[i].rwe));
        end
        idle(2);
        @(negedge clk);
        chk("idle_ram_addr_hold", 64'(ram_addr), 64'h02);
        chk("idle_ram_we", 64'(ram_we), 64'd0);
        drain("tbl_drain");

        // Two reads accepted, then reset: both responses must vanish
        drive(0, 0, '0, '0, 1, 0, 7'h04, '0);
        @(negedge clk);
        chk("pre_rst_r1_ready", 64'(r1_ready), 64'd1);
        drive(1, 0, 7'h03, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("pre_rst_r0_ready", 64'(r0_ready), 64'd1);
        b = rv_seen;
        @(posedge clk);
        #1;
        rst = 1'b1;
        r0_valid = 0; r1_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        @(negedge clk);
        chk("rst_dropped_rvalids", 64'(rv_seen - b), 64'd0);
        drive(1, 0, 7'h06, '0, 1, 0, 7'h07, '0);
        @(negedge clk);
        chk("post_rst_r0_wins", 64'(r0_ready), 64'd1);
        chk("post_rst_r1_waits", 64'(r1_ready), 64'd0);
        idle(1);
        drain("rst_drain");

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom(), $urandom()};
            rd0 = rnd[DW-1:0];
            rnd = {$urandom(), $urandom()};
            rd1 = rnd[DW-1:0];
            ra0 = ($urandom_range(9, 0) == 0) ? 7'h7F : 7'($urandom_range(15, 0));
            ra1 = ($urandom_range(9, 0) == 0) ? 7'h7F : 7'($urandom_range(15, 0));
            drive($urandom_range(9, 0) < 6, $urandom_range(3, 0) == 0, ra0, rd0,
                  $urandom_range(9, 0) < 6, $urandom_range(3, 0) == 0, ra1, rd1);
        end
        idle(1);
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_prom_port_arbiter
`default_nettype wire
